// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the rv32i core and a debug/loader master.
// Optional `DM_ARB_STATS_EN adds a saturating conflict_cnt output.
module dm_arbiter #(
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wd,
   output logic [DW-1:0] cpu_rd,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wd,
   input  logic          dbg_lock,
   output logic          dbg_gnt,
   output logic [DW-1:0] dbg_rd,
   output logic          dbg_rvalid,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wd,
   output logic          dm_we,
   input  logic [DW-1:0] dm_rd
`ifdef DM_ARB_STATS_EN
   ,
   output logic [15:0]   conflict_cnt
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t     state, state_nxt;
   logic       last_dbg;   // 1 when the most recent grant went to the debug master
   logic [3:0] wait_cnt;
   logic       cpu_gnt;
   logic       cpu_force;

   assign cpu_force = cpu_req && (wait_cnt == 4'(MAX_WAIT));

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!reset) begin
         if (cpu_force)                     cpu_gnt = 1'b1;
         else if (state == LOCKED && dbg_req) dbg_gnt = 1'b1;
         else if (cpu_req && dbg_req) begin
            if (last_dbg) cpu_gnt = 1'b1;
            else          dbg_gnt = 1'b1;
         end
         else if (cpu_req)                  cpu_gnt = 1'b1;
         else if (dbg_req)                  dbg_gnt = 1'b1;
      end
   end

   assign cpu_stall = cpu_req && !cpu_gnt && !reset;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dbg_gnt && dbg_lock) state_nxt = LOCKED;
         LOCKED:  if (!dbg_req || (dbg_gnt && !dbg_lock)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dm_addr = '0;
      dm_wd   = '0;
      dm_we   = 1'b0;
      cpu_rd  = '0;
      if (cpu_gnt) begin
         dm_addr = cpu_addr;
         dm_wd   = cpu_wd;
         dm_we   = cpu_we;
         cpu_rd  = dm_rd;
      end else if (dbg_gnt) begin
         dm_addr = dbg_addr;
         dm_wd   = dbg_wd;
         dm_we   = dbg_we;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_dbg   <= 1'b1;
         wait_cnt   <= '0;
         dbg_rd     <= '0;
         dbg_rvalid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cpu_gnt || dbg_gnt) last_dbg <= dbg_gnt;
         if (cpu_stall) begin
            if (wait_cnt != 4'(MAX_WAIT)) wait_cnt <= wait_cnt + 4'd1;
         end else begin
            wait_cnt <= '0;
         end
         dbg_rvalid <= dbg_gnt && !dbg_we;
         if (dbg_gnt && !dbg_we) dbg_rd <= dm_rd;
      end
   end

`ifdef DM_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          conflict_cnt <= '0;
      else if (cpu_req && dbg_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
   end
`endif

endmodule
